recepcao_medida_serial: RTL and testbench

Serial receiver for measurement messages: the far-end counterpart of the trena's serial transmitter. It deserializes asynchronous 7O2 characters from `entrada_serial`, assembles the message "d2 d1 d0 #" (three ASCII decimal digits, hundreds first, then `#`) and presents the value as 12-bit BCD. It sits on the receiving board or test fixture, driving 7-segment decoders and a host that consumes `medida`/`pronto`.

---
 rtl/serial_pkg.sv | 32 +++
 rtl/rx_serial_7O2.sv | 96 +++++++++
 rtl/recepcao_medida_serial.sv | 115 +++++++++++
 tb/tb_recepcao_medida_serial.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants and state encodings for the 7O2 measurement receiver.
package serial_pkg;

    localparam int CLOCKS_POR_BIT = 434;

    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] ASCII_NOVE = 7'h39;
    localparam logic [6:0] ASCII_HASH = 7'h23;

    typedef enum logic [2:0] {
        ocioso   = 3'd0,
        inicio   = 3'd1,
        dados    = 3'd2,
        paridade = 3'd3,
        parada   = 3'd4,
        entrega  = 3'd5
    } estado_char_t;

    // Codes double as the db_estado debug value; 4'hF is kept free.
    typedef enum logic [3:0] {
        esp_d2   = 4'd0,
        esp_d1   = 4'd1,
        esp_d0   = 4'd2,
        esp_hash = 4'd3,
        publica  = 4'd4
    } estado_msg_t;

    function automatic logic eh_digito(input logic [6:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NOVE);
    endfunction

endpackage

// File: rtl/rx_serial_7O2.sv
// Character receiver: synchronizer, bit-period down-counter and 7O2 deserializer.
// state    | meaning
// ocioso   | line idle, waiting for a falling edge
// inicio   | half bit wait, start bit re-checked
// dados    | 7 data bits sampled at bit centre, LSB first
// paridade | parity bit sampled
// parada   | first stop bit sampled
// entrega  | char and error flag offered for one cycle
module rx_serial_7O2
    import serial_pkg::*;
#(
    parameter int CLOCKS_POR_BIT = serial_pkg::CLOCKS_POR_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] dado,
    output logic       dado_valido,
    output logic       dado_erro
);

    localparam int CW = $clog2(CLOCKS_POR_BIT);
    localparam logic [CW-1:0] CARGA_MEIO = CW'(CLOCKS_POR_BIT / 2 - 1);
    localparam logic [CW-1:0] CARGA_BIT  = CW'(CLOCKS_POR_BIT - 1);

    estado_char_t estado, prox_estado;
    logic          sinc1, sinc2, linha_ant;
    logic [CW-1:0] cnt;
    logic [2:0]    bits_rest;
    logic [6:0]    shift;
    logic          erro_par;
    logic          fim_cnt, borda_desc;

    assign fim_cnt     = (cnt == '0);
    // Edge (not level) start detect: a line stuck low yields only one character.
    assign borda_desc  = linha_ant & ~sinc2;
    assign dado        = shift;
    assign dado_valido = (estado == entrega);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1     <= 1'b1;
            sinc2     <= 1'b1;
            linha_ant <= 1'b1;
        end else begin
            sinc1     <= entrada_serial;
            sinc2     <= sinc1;
            linha_ant <= sinc2;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            ocioso:   if (borda_desc) prox_estado = inicio;
            inicio:   if (fim_cnt) prox_estado = sinc2 ? ocioso : dados;
            dados:    if (fim_cnt && (bits_rest == 3'd0)) prox_estado = paridade;
            paridade: if (fim_cnt) prox_estado = parada;
            parada:   if (fim_cnt) prox_estado = entrega;
            entrega:  prox_estado = ocioso;
            default:  prox_estado = ocioso;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= ocioso;
            cnt       <= '0;
            bits_rest <= '0;
            shift     <= '0;
            erro_par  <= 1'b0;
            dado_erro <= 1'b0;
        end else begin
            estado <= prox_estado;
            if (estado == ocioso)
                cnt <= CARGA_MEIO;
            else if (fim_cnt)
                cnt <= CARGA_BIT;
            else
                cnt <= cnt - 1'b1;
            case (estado)
                inicio: bits_rest <= 3'd6;
                dados: begin
                    if (fim_cnt) begin
                        shift     <= {sinc2, shift[6:1]};
                        bits_rest <= bits_rest - 1'b1;
                    end
                end
                paridade: if (fim_cnt) erro_par <= ~(^{shift, sinc2});
                parada:   if (fim_cnt) dado_erro <= erro_par | ~sinc2;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/recepcao_medida_serial.sv
// Measurement message receiver: assembles "d2 d1 d0 #" into a 12-bit BCD value.
// state    | meaning
// esp_d2   | waiting for hundreds digit
// esp_d1   | waiting for tens digit
// esp_d0   | waiting for units digit
// esp_hash | waiting for the '#' terminator
// publica  | value just published, back to esp_d2
module recepcao_medida_serial
    import serial_pkg::*;
#(
    parameter int CLOCKS_POR_BIT = serial_pkg::CLOCKS_POR_BIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    estado_msg_t estado, prox_estado;
    logic [11:0] sombra, prox_sombra;
    logic        prox_pronto, prox_erro, rejeita;
    logic [6:0]  dado;
    logic        dado_valido, dado_erro;

    rx_serial_7O2 #(
        .CLOCKS_POR_BIT(CLOCKS_POR_BIT)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dado           (dado),
        .dado_valido    (dado_valido),
        .dado_erro      (dado_erro)
    );

    assign db_estado = estado;

    always_comb begin
        prox_estado = estado;
        prox_sombra = sombra;
        prox_pronto = 1'b0;
        prox_erro   = 1'b0;
        rejeita     = 1'b0;
        if (estado == publica) begin
            prox_estado = esp_d2;
        end else if (dado_valido) begin
            if (dado_erro) begin
                rejeita = 1'b1;
            end else begin
                case (estado)
                    // A stray '#' while idle is just a resync marker.
                    esp_d2: begin
                        if (eh_digito(dado)) begin
                            prox_sombra[11:8] = dado[3:0];
                            prox_estado       = esp_d1;
                        end else if (dado != ASCII_HASH) begin
                            rejeita = 1'b1;
                        end
                    end
                    esp_d1: begin
                        if (eh_digito(dado)) begin
                            prox_sombra[7:4] = dado[3:0];
                            prox_estado      = esp_d0;
                        end else begin
                            rejeita = 1'b1;
                        end
                    end
                    esp_d0: begin
                        if (eh_digito(dado)) begin
                            prox_sombra[3:0] = dado[3:0];
                            prox_estado      = esp_hash;
                        end else begin
                            rejeita = 1'b1;
                        end
                    end
                    esp_hash: begin
                        if (dado == ASCII_HASH) begin
                            prox_estado = publica;
                            prox_pronto = 1'b1;
                        end else begin
                            rejeita = 1'b1;
                        end
                    end
                    default: prox_estado = esp_d2;
                endcase
            end
            if (rejeita) begin
                prox_erro   = 1'b1;
                prox_estado = esp_d2;
                prox_sombra = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= esp_d2;
            sombra <= '0;
            medida <= '0;
            pronto <= 1'b0;
            erro   <= 1'b0;
        end else begin
            estado <= prox_estado;
            sombra <= prox_sombra;
            pronto <= prox_pronto;
            erro   <= prox_erro;
            if (prox_pronto)
                medida <= sombra;
        end
    end

endmodule

// File: tb/tb_recepcao_medida_serial.sv
// Directed bench for recepcao_medida_serial: message vector table plus corner sequences.
module tb_recepcao_medida_serial;

    localparam int CPB = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        entrada_serial;
    logic [11:0] medida;
    logic        pronto, erro;
    logic [3:0]  db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_stop   = 0;
    int cyc_pronto = 0;
    int n_pronto = 0, n_erro = 0, n_ambos = 0, n_medida_sem_pronto = 0;
    logic [11:0] medida_ant;
    logic [11:0] publicados[$];

    typedef struct {
        string       msg;
        logic        par_ruim;
        logic        stop_ruim;
        int          exp_pronto;
        int          exp_erro;
        logic [11:0] exp_medida;
        logic [3:0]  exp_estado;
    } vec_t;

    vec_t vt[12];

    recepcao_medida_serial #(
        .CLOCKS_POR_BIT(CPB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .medida         (medida),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pronto) begin
            n_pronto++;
            publicados.push_back(medida);
            cyc_pronto = cyc;
        end
        if (erro) n_erro++;
        if (pronto && erro) n_ambos++;
        if (!reset && !pronto && (medida !== medida_ant)) n_medida_sem_pronto++;
        medida_ant = medida;
    end

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic bit_periodo(input logic v);
        entrada_serial = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic envia(input logic [6:0] c, input logic par_ruim, input logic stop_ruim, input int nstop);
        logic p;
        p = ~(^c) ^ par_ruim;
        bit_periodo(1'b0);
        for (int i = 0; i < 7; i++) bit_periodo(c[i]);
        bit_periodo(p);
        t_stop = cyc;
        bit_periodo(~stop_ruim);
        for (int i = 1; i < nstop; i++) bit_periodo(1'b1);
    endtask

    task automatic envia_msg(input string s, input int nstop);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            envia(b[6:0], 1'b0, 1'b0, nstop);
        end
    endtask

    task automatic zera_contagem();
        n_pronto = 0;
        n_erro   = 0;
        publicados.delete();
    endtask

    initial begin
        vt[0]  = '{"123#", 1'b0, 1'b0, 1, 0, 12'h123, 4'd0};
        vt[1]  = '{"4",    1'b1, 1'b0, 0, 1, 12'h123, 4'd0};
        vt[2]  = '{"045#", 1'b0, 1'b0, 1, 0, 12'h045, 4'd0};
        vt[3]  = '{"12#",  1'b0, 1'b0, 0, 1, 12'h045, 4'd0};
        vt[4]  = '{"7A9#", 1'b0, 1'b0, 0, 2, 12'h045, 4'd0};
        vt[5]  = '{"999#", 1'b0, 1'b0, 1, 0, 12'h999, 4'd0};
        vt[6]  = '{"#",    1'b0, 1'b0, 0, 0, 12'h999, 4'd0};
        vt[7]  = '{"5",    1'b0, 1'b1, 0, 1, 12'h999, 4'd0};
        vt[8]  = '{"12",   1'b0, 1'b0, 0, 0, 12'h999, 4'd2};
        vt[9]  = '{"3A",   1'b0, 1'b0, 0, 1, 12'h999, 4'd0};
        vt[10] = '{"867",  1'b0, 1'b0, 0, 0, 12'h999, 4'd3};
        vt[11] = '{"#",    1'b0, 1'b0, 1, 0, 12'h867, 4'd0};

        reset = 1'b1;
        entrada_serial = 1'b1;
        repeat (5) @(negedge clock);
        verifica("reset medida", medida, 12'h000);
        verifica("reset pronto", pronto, 1'b0);
        verifica("reset erro", erro, 1'b0);
        verifica("reset db_estado", db_estado, 4'd0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);

        for (int k = 0; k < 12; k++) begin
            byte b;
            zera_contagem();
            for (int i = 0; i < vt[k].msg.len(); i++) begin
                b = vt[k].msg[i];
                envia(b[6:0], (i == 0) ? vt[k].par_ruim : 1'b0,
                      (i == 0) ? vt[k].stop_ruim : 1'b0, 2);
            end
            repeat (2 * CPB) @(negedge clock);
            verifica($sformatf("vec%0d pronto count", k), n_pronto, vt[k].exp_pronto);
            verifica($sformatf("vec%0d erro count", k), n_erro, vt[k].exp_erro);
            verifica($sformatf("vec%0d medida", k), medida, vt[k].exp_medida);
            verifica($sformatf("vec%0d db_estado", k), db_estado, vt[k].exp_estado);
            if (k == 0)
                verifica("pronto latency in window",
                         ((cyc_pronto - t_stop) >= 33) && ((cyc_pronto - t_stop) <= 39), 1'b1);
        end

        // Short low glitch mid-message must be ignored.
        zera_contagem();
        envia_msg("1", 2);
        verifica("glitch pre db_estado", db_estado, 4'd1);
        entrada_serial = 1'b0;
        repeat (20) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        verifica("glitch db_estado", db_estado, 4'd1);
        verifica("glitch erro count", n_erro, 0);
        envia_msg("23#", 2);
        repeat (2 * CPB) @(negedge clock);
        verifica("glitch then 123 medida", medida, 12'h123);
        verifica("glitch then 123 pronto", n_pronto, 1);

        // Line stuck low: exactly one framing error.
        zera_contagem();
        entrada_serial = 1'b0;
        repeat (20 * CPB) @(negedge clock);
        verifica("stuck low erro count", n_erro, 1);
        verifica("stuck low db_estado", db_estado, 4'd0);
        entrada_serial = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        verifica("stuck low release erro", n_erro, 1);
        verifica("stuck low pronto", n_pronto, 0);

        // Reset in the middle of the third character.
        envia_msg("98", 2);
        bit_periodo(1'b0);
        bit_periodo(1'b1);
        bit_periodo(1'b1);
        reset = 1'b1;
        @(negedge clock);
        verifica("midreset medida", medida, 12'h000);
        verifica("midreset pronto", pronto, 1'b0);
        verifica("midreset erro", erro, 1'b0);
        verifica("midreset db_estado", db_estado, 4'd0);
        entrada_serial = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);
        zera_contagem();
        envia_msg("500#", 2);
        repeat (2 * CPB) @(negedge clock);
        verifica("after reset medida", medida, 12'h500);
        verifica("after reset pronto", n_pronto, 1);
        verifica("after reset erro", n_erro, 0);

        // Back-to-back messages with one and with two stop bits.
        for (int ns = 1; ns <= 2; ns++) begin
            zera_contagem();
            envia_msg("321#654#", ns);
            repeat (2 * CPB) @(negedge clock);
            verifica($sformatf("b2b%0d pronto count", ns), n_pronto, 2);
            verifica($sformatf("b2b%0d first value", ns),
                     (publicados.size() > 0) ? publicados[0] : 12'hfff, 12'h321);
            verifica($sformatf("b2b%0d second value", ns),
                     (publicados.size() > 1) ? publicados[1] : 12'hfff, 12'h654);
            verifica($sformatf("b2b%0d erro count", ns), n_erro, 0);
        end

        verifica("pronto and erro together", n_ambos, 0);
        verifica("medida changed without pronto", n_medida_sem_pronto, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
